// File: rtl/encoder16_4_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot request vector and emits one
// index per valid/ready transfer. Define ENC_MSB_FIRST_EN to emit highest index first.
module encoder16_4_seq #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e,
  input  logic          load,
  input  logic [N-1:0]  d_in,
  output logic          load_ready,
  output logic [AW-1:0] idx,
  output logic          valid,
  input  logic          ready,
  output logic          empty_load,
  output logic          last
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pend, pend_nxt, clr_mask;
  logic         empty_nxt;

  // Priority encode of the pending vector; picks the bit that is served next.
  function automatic logic [AW-1:0] pick(input logic [N-1:0] v);
    pick = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++)
      if (v[i]) pick = AW'(i);
`else
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) pick = AW'(i);
`endif
  endfunction

  function automatic logic one_hot(input logic [N-1:0] v);
    one_hot = (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign valid      = (state == SCAN);
  assign load_ready = (state == IDLE);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    state_nxt = state;
    pend_nxt  = pend;
    empty_nxt = 1'b0;
    clr_mask  = '0;
    clr_mask[idx] = 1'b1;
    unique case (state)
      IDLE: begin
        if (load && e) begin
          if (d_in != '0) begin
            pend_nxt  = d_in;
            state_nxt = SCAN;
          end else begin
            empty_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (ready) begin
          pend_nxt = pend & ~clr_mask;
          if ((pend & ~clr_mask) == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx and last are registered from the next pend value so they stay stable
  // while a transfer is stalled and advance with no bubble when it is taken.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      idx        <= '0;
      last       <= 1'b0;
      empty_load <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      idx        <= pick(pend_nxt);
      last       <= one_hot(pend_nxt);
      empty_load <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_encoder16_4_seq.sv
// Directed self-checking bench for encoder16_4_seq; expected indices are queued
// when a vector is loaded and popped as each transfer is observed.
module tb_encoder16_4_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e = 1'b0;
  logic        load = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] d_in = '0;
  logic        load_ready, valid, empty_load, last;
  logic [3:0]  idx;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  encoder16_4_seq #(.N(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .e(e), .load(load), .d_in(d_in),
    .load_ready(load_ready), .idx(idx), .valid(valid), .ready(ready),
    .empty_load(empty_load), .last(last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge where outputs are sampled
  // and inputs for the next rising edge are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_vec(input logic [15:0] v);
`ifdef ENC_MSB_FIRST_EN
    for (int i = 15; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < 16; i++) if (v[i]) exp_q.push_back(i);
`endif
  endtask

  task automatic load_vec(input string tag, input logic [15:0] v);
    check({tag, " load_ready before"}, load_ready, 1);
    load = 1'b1;
    e    = 1'b1;
    d_in = v;
    push_vec(v);
    tick();
    load = 1'b0;
    e    = 1'b0;
  endtask

  task automatic drain(input string tag, input bit noise);
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, " valid"}, valid, 1);
      check({tag, " idx"}, idx, exp_q[0]);
      check({tag, " last"}, last, exp_q.size() == 1);
      if (noise) begin
        load = 1'b1;
        d_in = 16'h0001;
        e    = ~e;
      end
      void'(exp_q.pop_front());
      tick();
    end
    load = 1'b0;
    e    = 1'b0;
    check({tag, " valid after"}, valid, 0);
    check({tag, " load_ready after"}, load_ready, 1);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst valid", valid, 0);
    check("rst idx", idx, 0);
    check("rst last", last, 0);
    check("rst empty_load", empty_load, 0);
    check("rst load_ready", load_ready, 1);
    rst_n = 1'b1;
    tick();

    // Two-bit vector, ready held high
    ready = 1'b1;
    load_vec("v0005", 16'h0005);
    drain("v0005", 1'b0);

    // Full vector: 16 back-to-back transfers, no gaps
    load_vec("vFFFF", 16'hFFFF);
    drain("vFFFF", 1'b0);

    // Single high bit
    load_vec("v8000", 16'h8000);
    drain("v8000", 1'b0);

    // Stalled handshake: idx and valid hold while ready is low
    ready = 1'b0;
    load_vec("v0110", 16'h0110);
    for (int k = 0; k < 5; k++) begin
      check("v0110 stall valid", valid, 1);
      check("v0110 stall idx", idx, exp_q[0]);
      check("v0110 stall last", last, 0);
      tick();
    end
    drain("v0110", 1'b0);

    // Empty capture: one-cycle empty_load pulse, no valid
    load_vec("v0000", 16'h0000);
    check("v0000 empty_load", empty_load, 1);
    check("v0000 valid", valid, 0);
    check("v0000 load_ready", load_ready, 1);
    tick();
    check("v0000 empty_load drop", empty_load, 0);
    check("v0000 valid later", valid, 0);

    // Load attempts and e toggling during a scan are ignored
    load_vec("v00F0", 16'h00F0);
    drain("v00F0", 1'b1);
    tick();
    check("v00F0 no extra valid", valid, 0);

    // Reset in the middle of a scan discards remaining bits
    ready = 1'b1;
    load_vec("v0F00", 16'h0F00);
    check("v0F00 valid", valid, 1);
    check("v0F00 idx", idx, exp_q[0]);
    void'(exp_q.pop_front());
    tick();
    check("v0F00 second idx", idx, exp_q[0]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst valid", valid, 0);
    check("midrst load_ready", load_ready, 1);
    check("midrst idx", idx, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst stays idle", valid, 0);
    end

    // Block is usable again after the reset
    load_vec("v0003", 16'h0003);
    drain("v0003", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
